// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - push-button/switch-bank signal bundle between pins and the debouncer.
interface key_debounce_if;
   logic        key_raw;
   logic [15:0] sw_raw;
   logic        key_out;
   logic [15:0] sw_out;
   logic        press_pulse;
   logic        release_pulse;

   modport master (
      output key_raw, sw_raw,
      input  key_out, sw_out, press_pulse, release_pulse
   );

   modport slave (
      input  key_raw, sw_raw,
      output key_out, sw_out, press_pulse, release_pulse
   );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizes and debounces a push-button and latches the switch bank
// while the key is held.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   key_debounce_if.slave bus
);
   localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          key_s1;
   logic          key_s2;
   logic [15:0]   sw_s1;
   logic [15:0]   sw_s2;
   logic          key_s;

   // Synchronizers reset to the not-pressed pin level so no phantom press follows reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1 <= KEY_ACTIVE_LOW;
         key_s2 <= KEY_ACTIVE_LOW;
         sw_s1  <= 16'h0000;
         sw_s2  <= 16'h0000;
      end else begin
         key_s1 <= bus.key_raw;
         key_s2 <= key_s1;
         sw_s1  <= bus.sw_raw;
         sw_s2  <= sw_s1;
      end
   end

   assign key_s = KEY_ACTIVE_LOW ? ~key_s2 : key_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         cnt               <= '0;
         bus.key_out       <= 1'b0;
         bus.press_pulse   <= 1'b0;
         bus.release_pulse <= 1'b0;
         bus.sw_out        <= 16'h0000;
      end else begin
         bus.press_pulse   <= 1'b0;
         bus.release_pulse <= 1'b0;
         // Switch value is frozen for the whole time the key reads pressed.
         if (!bus.key_out) begin
            bus.sw_out <= sw_s2;
         end
         case (state)
            IDLE: begin
               if (key_s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!key_s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state           <= PRESSED;
                  cnt             <= '0;
                  bus.key_out     <= 1'b1;
                  bus.press_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!key_s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (key_s) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state             <= IDLE;
                  cnt               <= '0;
                  bus.key_out       <= 1'b0;
                  bus.release_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               cnt         <= '0;
               bus.key_out <= 1'b0;
            end
         endcase
      end
   end
endmodule
